// File: rtl/jtpopeye_inputs_pkg.sv
// Shared constants for the Popeye cabinet input conditioner: PS/2 scancodes,
// held-key vector layout, joystick word bit positions and coin FSM states.
package jtpopeye_inputs_pkg;

  // Player 1 scancodes
  localparam logic [7:0] KEY_UP       = 8'h75;
  localparam logic [7:0] KEY_DOWN     = 8'h72;
  localparam logic [7:0] KEY_LEFT     = 8'h6B;
  localparam logic [7:0] KEY_RIGHT    = 8'h74;
  localparam logic [7:0] KEY_PUNCH    = 8'h14;
  // Player 2 scancodes
  localparam logic [7:0] KEY_P2_UP    = 8'h1D;
  localparam logic [7:0] KEY_P2_DOWN  = 8'h1B;
  localparam logic [7:0] KEY_P2_LEFT  = 8'h1C;
  localparam logic [7:0] KEY_P2_RIGHT = 8'h23;
  localparam logic [7:0] KEY_P2_PUNCH = 8'h12;
  // System scancodes
  localparam logic [7:0] KEY_START1   = 8'h05;
  localparam logic [7:0] KEY_START2   = 8'h06;
  localparam logic [7:0] KEY_COIN     = 8'h04;
  localparam logic [7:0] KEY_PAUSE    = 8'h0C;

  // Held-key vector: each player slice matches the {punch,up,down,left,right} output order
  localparam int KEY_N       = 14;
  localparam int KI_P1_RIGHT = 0;
  localparam int KI_P1_LEFT  = 1;
  localparam int KI_P1_DOWN  = 2;
  localparam int KI_P1_UP    = 3;
  localparam int KI_P1_PUNCH = 4;
  localparam int KI_P2_RIGHT = 5;
  localparam int KI_P2_LEFT  = 6;
  localparam int KI_P2_DOWN  = 7;
  localparam int KI_P2_UP    = 8;
  localparam int KI_P2_PUNCH = 9;
  localparam int KI_START1   = 10;
  localparam int KI_START2   = 11;
  localparam int KI_COIN     = 12;
  localparam int KI_PAUSE    = 13;

  // Joystick word bit positions
  localparam int JB_RIGHT  = 0;
  localparam int JB_LEFT   = 1;
  localparam int JB_DOWN   = 2;
  localparam int JB_UP     = 3;
  localparam int JB_PUNCH  = 4;
  localparam int JB_START1 = 6;
  localparam int JB_START2 = 7;
  localparam int JB_COIN   = 8;
  localparam int JB_PAUSE  = 9;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE    = 2'd1,
    WAIT_REL = 2'd2
  } coin_state_t;

endpackage

// File: rtl/jtpopeye_ps2_keys.sv
// PS/2 event decoder: detects the event toggle and keeps one held/released
// register per mapped scancode.
module jtpopeye_ps2_keys
  import jtpopeye_inputs_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       ps2_key,
  output logic [KEY_N-1:0]  o_keys
);

  logic             r_toggle;
  logic [KEY_N-1:0] r_keys;
  logic             w_event;
  logic             w_hit;
  logic [3:0]       w_idx;
  logic             w_unused_ext;

  // The extended-code flag plays no part in the map
  assign w_unused_ext = ps2_key[8];
  assign w_event      = ps2_key[10] ^ r_toggle;

  always_comb begin
    w_hit = 1'b1;
    w_idx = 4'd0;
    case (ps2_key[7:0])
      KEY_RIGHT:    w_idx = 4'(KI_P1_RIGHT);
      KEY_LEFT:     w_idx = 4'(KI_P1_LEFT);
      KEY_DOWN:     w_idx = 4'(KI_P1_DOWN);
      KEY_UP:       w_idx = 4'(KI_P1_UP);
      KEY_PUNCH:    w_idx = 4'(KI_P1_PUNCH);
      KEY_P2_RIGHT: w_idx = 4'(KI_P2_RIGHT);
      KEY_P2_LEFT:  w_idx = 4'(KI_P2_LEFT);
      KEY_P2_DOWN:  w_idx = 4'(KI_P2_DOWN);
      KEY_P2_UP:    w_idx = 4'(KI_P2_UP);
      KEY_P2_PUNCH: w_idx = 4'(KI_P2_PUNCH);
      KEY_START1:   w_idx = 4'(KI_START1);
      KEY_START2:   w_idx = 4'(KI_START2);
      KEY_COIN:     w_idx = 4'(KI_COIN);
      KEY_PAUSE:    w_idx = 4'(KI_PAUSE);
      default:      w_hit = 1'b0;
    endcase
  end

  // Toggle reloads from the live bit in reset so releasing reset never fires an event
  always_ff @(posedge clk) begin
    if (rst) begin
      r_toggle <= ps2_key[10];
      r_keys   <= '0;
    end else begin
      r_toggle <= ps2_key[10];
      if (w_event && w_hit) r_keys[w_idx] <= ps2_key[9];
    end
  end

  assign o_keys = r_keys;

endmodule

// File: rtl/jtpopeye_inputs.sv
// Cabinet input conditioner: merges keyboard and joystick sources into
// registered player controls, a pause toggle and a one-shot coin pulse.
module jtpopeye_inputs
  import jtpopeye_inputs_pkg::*;
#(
  parameter int COIN_W = 400000
)(
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joy_0,
  input  logic [15:0] joy_1,
  input  logic        clr_pause,
  output logic [4:0]  joystick1,
  output logic [4:0]  joystick2,
  output logic [1:0]  start_button,
  output logic        coin_input,
  output logic        pause,
  output logic [1:0]  o_coin_state
);

  localparam int CNT_W = $clog2(COIN_W + 1);

  logic [KEY_N-1:0] w_keys;
  logic [4:0]       r_joy1;
  logic [4:0]       r_joy2;
  logic [1:0]       r_start;
  logic             r_pause;
  logic             r_pause_prev;
  logic             w_pause_req;
  logic             w_coin_req;
  coin_state_t      r_state;
  coin_state_t      w_state_n;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_n;
  logic             r_coin;
  logic             w_coin_n;
  logic             w_unused;

  assign w_unused = ^{joy_0[15:10], joy_0[5], joy_1[15:5]};

  jtpopeye_ps2_keys u_keys (
    .clk     (clk),
    .rst     (rst),
    .ps2_key (ps2_key),
    .o_keys  (w_keys)
  );

  assign w_pause_req = w_keys[KI_PAUSE] | joy_0[JB_PAUSE];
  assign w_coin_req  = w_keys[KI_COIN]  | joy_0[JB_COIN];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_joy1  <= '0;
      r_joy2  <= '0;
      r_start <= '0;
    end else begin
      r_joy1  <= w_keys[KI_P1_PUNCH:KI_P1_RIGHT] | joy_0[JB_PUNCH:JB_RIGHT];
      r_joy2  <= w_keys[KI_P2_PUNCH:KI_P2_RIGHT] | joy_1[JB_PUNCH:JB_RIGHT];
      r_start <= {w_keys[KI_START2] | joy_0[JB_START2],
                  w_keys[KI_START1] | joy_0[JB_START1]};
    end
  end

  // pause_prev resets high so a request held through reset is not an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pause      <= 1'b0;
      r_pause_prev <= 1'b1;
    end else begin
      r_pause_prev <= w_pause_req;
      if (clr_pause)                        r_pause <= 1'b0;
      else if (w_pause_req && !r_pause_prev) r_pause <= ~r_pause;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= WAIT_REL;
      r_cnt   <= '0;
      r_coin  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_coin  <= w_coin_n;
    end
  end

  // Pulse length is fixed at COIN_W cycles; the request is only re-armed after release
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_coin_n  = r_coin;
    case (r_state)
      IDLE: begin
        if (w_coin_req) begin
          w_state_n = PULSE;
          w_cnt_n   = CNT_W'(COIN_W - 1);
          w_coin_n  = 1'b1;
        end
      end
      PULSE: begin
        if (r_cnt == '0) begin
          w_state_n = WAIT_REL;
          w_coin_n  = 1'b0;
        end else begin
          w_cnt_n = r_cnt - CNT_W'(1);
        end
      end
      WAIT_REL: begin
        if (!w_coin_req) w_state_n = IDLE;
      end
      default: begin
        w_state_n = WAIT_REL;
        w_coin_n  = 1'b0;
      end
    endcase
  end

  assign joystick1    = r_joy1;
  assign joystick2    = r_joy2;
  assign start_button = r_start;
  assign coin_input   = r_coin;
  assign pause        = r_pause;
  assign o_coin_state = r_state;

endmodule

// File: tb/tb_jtpopeye_inputs.sv
// Bench for jtpopeye_inputs: table of merge vectors plus directed sequences
// for latency, reset, pause and coin pulse behaviour.
module tb_jtpopeye_inputs;

  localparam int COIN_W = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] ps2_key;
  logic [15:0] joy_0;
  logic [15:0] joy_1;
  logic        clr_pause;
  logic [4:0]  joystick1;
  logic [4:0]  joystick2;
  logic [1:0]  start_button;
  logic        coin_input;
  logic        pause;
  logic [1:0]  coin_state;

  int n_checks = 0;
  int n_pass   = 0;

  jtpopeye_inputs #(.COIN_W(COIN_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .ps2_key      (ps2_key),
    .joy_0        (joy_0),
    .joy_1        (joy_1),
    .clr_pause    (clr_pause),
    .joystick1    (joystick1),
    .joystick2    (joystick2),
    .start_button (start_button),
    .coin_input   (coin_input),
    .pause        (pause),
    .o_coin_state (coin_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // driver tasks
  task automatic kb(input logic pr, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pr, 1'b0, code};
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Runs n cycles, optionally dropping joy_0[8] after rel_after edges
  task automatic coin_run(input int n, input int rel_after, output int hi, output int pulses);
    logic prev;
    hi = 0;
    pulses = 0;
    prev = coin_input;
    for (int i = 0; i < n; i++) begin
      if (i == rel_after) joy_0[8] = 1'b0;
      tick();
      if (coin_input) hi++;
      if (coin_input && !prev) pulses++;
      prev = coin_input;
    end
  endtask

  typedef struct {
    logic        ev;
    logic        pr;
    logic        ext;
    logic [7:0]  code;
    logic [15:0] j0;
    logic [15:0] j1;
    logic [4:0]  e_j1;
    logic [4:0]  e_j2;
    logic [1:0]  e_st;
  } vec_t;

  vec_t vecs[30];

  function automatic vec_t mk(input logic ev, input logic pr, input logic ext,
                              input logic [7:0] code, input logic [15:0] j0,
                              input logic [15:0] j1, input logic [4:0] e_j1,
                              input logic [4:0] e_j2, input logic [1:0] e_st);
    vec_t v;
    v.ev = ev; v.pr = pr; v.ext = ext; v.code = code; v.j0 = j0; v.j1 = j1;
    v.e_j1 = e_j1; v.e_j2 = e_j2; v.e_st = e_st;
    return v;
  endfunction

  // scoreboard for the coin pulse widths
  logic [31:0] exp_q[$];

  int hi, pulses;

  initial begin
    // Key state accumulates row to row; expectations are cumulative
    vecs[0]  = mk(1, 1, 0, 8'h14, 16'h0000, 16'h0000, 5'b10000, 5'b00000, 2'b00);
    vecs[1]  = mk(1, 0, 0, 8'h14, 16'h0000, 16'h0000, 5'b00000, 5'b00000, 2'b00);
    vecs[2]  = mk(1, 1, 0, 8'h75, 16'h0000, 16'h0000, 5'b01000, 5'b00000, 2'b00);
    vecs[3]  = mk(0, 1, 0, 8'h75, 16'h0001, 16'h0000, 5'b01001, 5'b00000, 2'b00);
    vecs[4]  = mk(1, 1, 0, 8'h6B, 16'h0001, 16'h0000, 5'b01011, 5'b00000, 2'b00);
    vecs[5]  = mk(1, 0, 0, 8'h75, 16'h0001, 16'h0000, 5'b00011, 5'b00000, 2'b00);
    vecs[6]  = mk(0, 0, 0, 8'h75, 16'h0000, 16'h0000, 5'b00010, 5'b00000, 2'b00);
    vecs[7]  = mk(1, 0, 0, 8'h6B, 16'h0000, 16'h0000, 5'b00000, 5'b00000, 2'b00);
    vecs[8]  = mk(1, 1, 0, 8'h72, 16'h0000, 16'h0000, 5'b00100, 5'b00000, 2'b00);
    vecs[9]  = mk(1, 1, 0, 8'h74, 16'h0000, 16'h0000, 5'b00101, 5'b00000, 2'b00);
    vecs[10] = mk(1, 0, 0, 8'h72, 16'h0000, 16'h0000, 5'b00001, 5'b00000, 2'b00);
    vecs[11] = mk(1, 0, 0, 8'h74, 16'h0000, 16'h0000, 5'b00000, 5'b00000, 2'b00);
    vecs[12] = mk(1, 1, 0, 8'h05, 16'h0000, 16'h0000, 5'b00000, 5'b00000, 2'b01);
    vecs[13] = mk(0, 1, 0, 8'h05, 16'h0080, 16'h0000, 5'b00000, 5'b00000, 2'b11);
    vecs[14] = mk(1, 0, 0, 8'h05, 16'h0080, 16'h0000, 5'b00000, 5'b00000, 2'b10);
    vecs[15] = mk(1, 1, 0, 8'h06, 16'h0000, 16'h0000, 5'b00000, 5'b00000, 2'b10);
    vecs[16] = mk(1, 0, 0, 8'h06, 16'h0000, 16'h0000, 5'b00000, 5'b00000, 2'b00);
    vecs[17] = mk(1, 1, 0, 8'h23, 16'h0000, 16'h0000, 5'b00000, 5'b00001, 2'b00);
    vecs[18] = mk(0, 1, 0, 8'h23, 16'h0000, 16'h0010, 5'b00000, 5'b10001, 2'b00);
    vecs[19] = mk(1, 0, 0, 8'h23, 16'h0000, 16'h0010, 5'b00000, 5'b10000, 2'b00);
    vecs[20] = mk(1, 1, 0, 8'h1C, 16'h0000, 16'h0000, 5'b00000, 5'b00010, 2'b00);
    vecs[21] = mk(1, 1, 0, 8'h12, 16'h0000, 16'h0000, 5'b00000, 5'b10010, 2'b00);
    vecs[22] = mk(1, 0, 0, 8'h1C, 16'h0000, 16'h0000, 5'b00000, 5'b10000, 2'b00);
    vecs[23] = mk(1, 0, 0, 8'h12, 16'h0000, 16'h0000, 5'b00000, 5'b00000, 2'b00);
    vecs[24] = mk(1, 1, 0, 8'h99, 16'h0000, 16'h0000, 5'b00000, 5'b00000, 2'b00);
    vecs[25] = mk(1, 1, 1, 8'h1B, 16'h0000, 16'h0000, 5'b00000, 5'b00100, 2'b00);
    vecs[26] = mk(1, 0, 1, 8'h1B, 16'h0000, 16'h0000, 5'b00000, 5'b00000, 2'b00);
    vecs[27] = mk(0, 1, 0, 8'h14, 16'h0000, 16'h0000, 5'b00000, 5'b00000, 2'b00);
    vecs[28] = mk(0, 0, 0, 8'h14, 16'h001F, 16'h001F, 5'b11111, 5'b11111, 2'b00);
    vecs[29] = mk(0, 0, 0, 8'h14, 16'h0000, 16'h0000, 5'b00000, 5'b00000, 2'b00);

    // reset with the toggle bit high and a press pending on the bus
    rst = 1'b1;
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h14};
    joy_0 = '0;
    joy_1 = '0;
    clr_pause = 1'b0;
    ticks(3);
    rst = 1'b0;
    ticks(3);
    check("rst_joystick1", 32'(joystick1), 32'h0);
    check("rst_joystick2", 32'(joystick2), 32'h0);
    check("rst_start", 32'(start_button), 32'h0);
    check("rst_coin", 32'(coin_input), 32'h0);
    check("rst_pause", 32'(pause), 32'h0);

    // key latency: two clocks from the toggle
    kb(1'b1, 8'h14);
    tick();
    check("key_lat1", 32'(joystick1), 32'h0);
    tick();
    check("key_lat2", 32'(joystick1), 32'h10);
    kb(1'b0, 8'h14);
    ticks(2);
    check("key_release", 32'(joystick1), 32'h0);
    // joystick latency: one clock
    joy_0 = 16'h0008;
    tick();
    check("joy_lat1", 32'(joystick1), 32'h08);
    joy_0 = '0;
    tick();

    // table-driven merge vectors
    for (int i = 0; i < 30; i++) begin
      ps2_key = {vecs[i].ev ? ~ps2_key[10] : ps2_key[10], vecs[i].pr, vecs[i].ext, vecs[i].code};
      joy_0 = vecs[i].j0;
      joy_1 = vecs[i].j1;
      ticks(2);
      check($sformatf("vec%0d_j1", i), 32'(joystick1), 32'(vecs[i].e_j1));
      check($sformatf("vec%0d_j2", i), 32'(joystick2), 32'(vecs[i].e_j2));
      check($sformatf("vec%0d_st", i), 32'(start_button), 32'(vecs[i].e_st));
    end

    // merge: key and joystick on P2 up
    joy_1 = 16'h0008;
    kb(1'b1, 8'h1D);
    ticks(2);
    check("merge_both", 32'(joystick2), 32'h08);
    kb(1'b0, 8'h1D);
    ticks(2);
    check("merge_key_rel", 32'(joystick2), 32'h08);
    joy_1 = '0;
    tick();
    check("merge_joy_rel", 32'(joystick2), 32'h0);

    // pause via joystick, second edge lost to clr_pause
    joy_0 = 16'h0200;
    tick();
    check("pause_on", 32'(pause), 32'h1);
    joy_0 = '0;
    ticks(2);
    check("pause_hold", 32'(pause), 32'h1);
    joy_0 = 16'h0200;
    clr_pause = 1'b1;
    tick();
    check("pause_clr", 32'(pause), 32'h0);
    clr_pause = 1'b0;
    ticks(3);
    check("pause_clr_stay", 32'(pause), 32'h0);
    joy_0 = '0;
    tick();
    // pause via keyboard: two clocks from the toggle
    kb(1'b1, 8'h0C);
    tick();
    check("pause_key_lat1", 32'(pause), 32'h0);
    tick();
    check("pause_key_on", 32'(pause), 32'h1);
    kb(1'b0, 8'h0C);
    ticks(2);
    check("pause_key_rel", 32'(pause), 32'h1);
    kb(1'b1, 8'h0C);
    ticks(2);
    check("pause_key_off", 32'(pause), 32'h0);
    kb(1'b0, 8'h0C);
    ticks(2);

    // coin pulses: each run's expected high-cycle count is queued here
    exp_q.push_back(32'(COIN_W));  // held 100 clocks
    exp_q.push_back(32'(COIN_W));  // second press
    exp_q.push_back(32'(COIN_W));  // released mid-pulse
    exp_q.push_back(32'(COIN_W));  // pressed right after pulse ended
    exp_q.push_back(32'(COIN_W));  // keyboard coin
    exp_q.push_back(32'h0);        // held through reset
    exp_q.push_back(32'(COIN_W));  // fresh press after that

    joy_0 = 16'h0100;
    coin_run(100, 100, hi, pulses);
    check("coin_held_width", 32'(hi), exp_q.pop_front());
    check("coin_held_count", 32'(pulses), 32'h1);
    joy_0 = '0;
    ticks(2);
    joy_0 = 16'h0100;
    coin_run(20, 20, hi, pulses);
    check("coin_second_width", 32'(hi), exp_q.pop_front());
    joy_0 = '0;
    ticks(2);
    joy_0 = 16'h0100;
    coin_run(20, 2, hi, pulses);
    check("coin_early_rel_width", 32'(hi), exp_q.pop_front());
    joy_0 = 16'h0100;
    coin_run(20, 20, hi, pulses);
    check("coin_rearm_width", 32'(hi), exp_q.pop_front());
    check("coin_rearm_count", 32'(pulses), 32'h1);
    joy_0 = '0;
    ticks(2);
    kb(1'b1, 8'h04);
    coin_run(20, 20, hi, pulses);
    check("coin_key_width", 32'(hi), exp_q.pop_front());
    kb(1'b0, 8'h04);
    ticks(3);

    // coin held through reset is ignored until released
    joy_0 = 16'h0100;
    rst = 1'b1;
    ticks(3);
    rst = 1'b0;
    coin_run(20, 20, hi, pulses);
    check("coin_thru_rst", 32'(hi), exp_q.pop_front());
    joy_0 = '0;
    ticks(2);
    joy_0 = 16'h0100;
    coin_run(20, 3, hi, pulses);
    check("coin_after_rst", 32'(hi), exp_q.pop_front());
    check("coin_after_rst_count", 32'(pulses), 32'h1);

    // reset mid-pulse drops coin_input on the next edge
    ticks(2);
    joy_0 = 16'h0100;
    ticks(3);
    check("coin_mid_high", 32'(coin_input), 32'h1);
    rst = 1'b1;
    tick();
    check("coin_mid_rst", 32'(coin_input), 32'h0);
    rst = 1'b0;
    coin_run(10, 10, hi, pulses);
    check("coin_mid_wait", 32'(hi), 32'h0);
    check("coin_q_empty", 32'(exp_q.size()), 32'h0);
    joy_0 = '0;
    ticks(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
